// File: rtl/ext_pipe.sv
// ext_pipe: two-stage valid/ready immediate-extension unit.
//   Picks a low-order field of in_data (5/6/8/9/11/IN_W bits by width_sel),
//   sign- or zero-extends it to OUT_W, and optionally shifts it left by one.
//   width_sel 6/7 is illegal: the word still flows, with out_data=0 and out_err=1.
//   out_ovf flags a significant bit lost by the shift.
// Ports:
//   clk_50, rst                   clock, async active-high reset
//   in_valid/in_ready/in_data     input handshake and source word
//   width_sel, sext, lshf         field select, sign/zero extend, shift-left-by-1
//   out_valid/out_ready           output handshake
//   out_data, out_err, out_ovf    result and per-transaction sideband flags
module ext_pipe #(
    parameter int IN_W  = 16,   // >= 11
    parameter int OUT_W = 16    // >= IN_W
) (
    input  logic             clk_50,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic [2:0]       width_sel,
    input  logic             sext,
    input  logic             lshf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_err,
    output logic             out_ovf
);
    localparam int STAGES = 2;

    // vld_pipe[1]: stage 1 holds a word; vld_pipe[2]: output register valid
    logic [STAGES:1] vld_pipe;
    logic [IN_W-1:0] s1_data;
    logic [2:0]      s1_wsel;
    logic            s1_sext;
    logic            s1_lshf;

    logic s2_free, in_fire;

    assign out_valid = vld_pipe[2];
    assign s2_free   = !vld_pipe[2] || out_ready;
    assign in_ready  = !vld_pipe[1] || s2_free;
    assign in_fire   = in_valid && in_ready;

    // Extension datapath, fed only from stage-1 registers
    logic [OUT_W-1:0] src, mask, ext, shifted;
    logic [OUT_W-1:0] res_data;
    logic             sign, illegal, ovf, res_err, res_ovf;

    assign src = OUT_W'(s1_data);

    always_comb begin
        mask    = '0;
        sign    = 1'b0;
        illegal = 1'b0;
        case (s1_wsel)
            3'd0: begin mask = ~({OUT_W{1'b1}} << 5);    sign = s1_data[4];      end
            3'd1: begin mask = ~({OUT_W{1'b1}} << 6);    sign = s1_data[5];      end
            3'd2: begin mask = ~({OUT_W{1'b1}} << 8);    sign = s1_data[7];      end
            3'd3: begin mask = ~({OUT_W{1'b1}} << 9);    sign = s1_data[8];      end
            3'd4: begin mask = ~({OUT_W{1'b1}} << 11);   sign = s1_data[10];     end
            // shift by OUT_W yields 0, so mask is all ones when IN_W == OUT_W
            3'd5: begin mask = ~({OUT_W{1'b1}} << IN_W); sign = s1_data[IN_W-1]; end
            default: illegal = 1'b1;
        endcase
    end

    // Upper bits past the field are filled with the field's sign when sext is set
    assign ext     = (src & mask) | ((s1_sext && sign) ? ~mask : '0);
    assign shifted = s1_lshf ? {ext[OUT_W-2:0], 1'b0} : ext;
    // Signed: top two bits differ means doubled value leaves the signed range.
    // Unsigned: a set MSB is simply shifted out.
    assign ovf      = s1_lshf && (s1_sext ? (ext[OUT_W-1] ^ ext[OUT_W-2]) : ext[OUT_W-1]);
    assign res_data = illegal ? '0 : shifted;
    assign res_err  = illegal;
    assign res_ovf  = !illegal && ovf;

    always_ff @(posedge clk_50 or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            s1_data  <= '0;
            s1_wsel  <= '0;
            s1_sext  <= 1'b0;
            s1_lshf  <= 1'b0;
            out_data <= '0;
            out_err  <= 1'b0;
            out_ovf  <= 1'b0;
        end else begin
            // Stage 1: load on input transfer, empty when its word moves on
            if (in_fire) begin
                vld_pipe[1] <= 1'b1;
                s1_data     <= in_data;
                s1_wsel     <= width_sel;
                s1_sext     <= sext;
                s1_lshf     <= lshf;
            end else if (s2_free) begin
                vld_pipe[1] <= 1'b0;
            end
            // Stage 2: output fields only change when the register is free
            if (s2_free) begin
                vld_pipe[2] <= vld_pipe[1];
                if (vld_pipe[1]) begin
                    out_data <= res_data;
                    out_err  <= res_err;
                    out_ovf  <= res_ovf;
                end
            end
        end
    end
endmodule

// File: doc/ext_pipe.md
Name: ext_pipe

Overview:
- Parametrised, pipelined immediate-extension unit for the LC-3b datapath; successor to the fixed 8-to-16 zero extender.
- Selects a low-order field of the input word: imm5, offset6, trapvect8, PCoffset9, PCoffset11 or full width.
- Sign- or zero-extends the field to OUT_W, optionally left-shifts by one (LSHF1), and flags illegal modes and shift overflow.
- Two-stage valid/ready pipeline sits between decode and the address/ALU operand muxes.

Parameters:
- IN_W, 16, input word width; must be >= 11.
- OUT_W, 16, output width; must be >= IN_W.

Ports:
- clk_50  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input word and mode are valid.
- in_ready  out  1  stage 1 can accept; transfer occurs when in_valid && in_ready at a clock edge.
- in_data  in  IN_W  source word (instruction or operand).
- width_sel  in  3  field select: 0=5b, 1=6b, 2=8b, 3=9b, 4=11b, 5=IN_W bits, 6/7=illegal.
- sext  in  1  1 = sign-extend; 0 = zero-extend.
- lshf  in  1  1 = shift the extended result left by 1, LSB filled with 0.
- out_valid  out  1  out_data, out_err and out_ovf are valid.
- out_ready  in  1  consumer accepts; transfer occurs when out_valid && out_ready.
- out_data  out  OUT_W  extended (and optionally shifted) result.
- out_err  out  1  transaction used an illegal width_sel.
- out_ovf  out  1  lshf discarded a significant bit.

Behaviour:
- Reset (asynchronous, while rst=1):
  - Stage 1 and stage 2 valid bits cleared; out_valid=0, out_data=0, out_err=0, out_ovf=0.
  - in_ready=1 once rst deasserts. in_ready is combinational, so it may read 1 during reset; no transfer occurs while rst=1.
  - Reset mid-transaction drops all in-flight words; nothing is replayed.
- Stage 1: registers in_data, width_sel, sext, lshf on an input transfer.
- Stage 2: computes the result from stage 1 registers and registers out_data/out_err/out_ovf/out_valid.
- Latency: 2 cycles from input transfer to out_valid with no backpressure. Throughput is 1 word/cycle while out_ready=1.
- Handshake:
  - s2_free = !out_valid || out_ready.
  - Stage 1 advances into stage 2 when s1_valid && s2_free.
  - in_ready = !s1_valid || s2_free (combinational; no dependency on in_valid).
  - While out_valid && !out_ready, all output fields hold stable. Stage 1 holds if full; if empty, it accepts one word and then stalls.
  - Simultaneous out transfer, stage1→stage2 move and input transfer in one cycle is legal and loses nothing.
- Extension, with field width W from width_sel:
  - f = in_data[W-1:0].
  - ext = sext ? {(OUT_W-W){f[W-1]}, f} : zero-padded f.
- Shift:
  - If lshf=1: out_data = {ext[OUT_W-2:0], 1'b0}; otherwise out_data = ext.
  - out_ovf = lshf && (sext ? ext[OUT_W-1] != ext[OUT_W-2] : ext[OUT_W-1]).
  - out_ovf is only ever set when W=OUT_W (width_sel=5 with IN_W=OUT_W); it is 0 in every other case.
- Illegal width_sel (6/7): out_data=0, out_err=1, out_ovf=0. The transaction still flows through the pipeline and is not dropped.
- out_err and out_ovf are per-transaction sideband; they are not sticky.
- No combinational path from in_* to out_*.

Test Plan:
- Reset then in_data=16'h001F, width_sel=0, sext=1, lshf=0, out_ready=1 → out_valid rises 2 cycles after transfer; out_data=16'hFFFF, err=0, ovf=0.
- in_data=16'h01FF, width_sel=3, sext=1, lshf=1 → out_data=16'hFFFE. Same word with sext=0, lshf=0 → 16'h01FF.
- Back-to-back stream of 8 words (width_sel=2, sext=0, in_data=0x00..0x07, one per cycle), out_ready=1 → outputs 0x0000..0x0007 in order on consecutive cycles; in_ready stays 1.
- Backpressure: out_ready=0 for 4 cycles during a stream → in_ready falls after 2 accepted words; out_data holds; no loss or duplication once out_ready=1.
- width_sel=5, in_data=16'h4000, sext=1, lshf=1 → out_data=16'h8000, ovf=1. width_sel=7 → out_data=0, err=1.
- Assert rst asynchronously mid-clock with both stages full → out_valid=0 and out_data=0 immediately. After release, the first new word emerges 2 cycles after its transfer; the old words never appear.
